multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath. Replaces single-cycle decode with a Moore FSM that steps the shared
//  ALU/memory datapath through fetch, decode, execute, memory and writeback. Waits on a ready handshake for the
//  unified instruction/data memory. Sits between the IR/flags and the datapath mux/write-enable controls.
// PARAMETERS
//  CNT_W    32   width of retired-instruction counter
//  TMO_CYC  255  memory-wait cycles before timeout trap (only with MC_MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  op         in   6      IR[31:26]
//  funct      in   6      IR[5:0]
//  zero       in   1      ALU zero flag, valid in BRANCH
//  mem_ready  in   1      memory completes transfer at this edge when high with mem_req
//  mem_req    out  1      memory access request
//  mem_we     out  1      write qualifier for mem_req
//  iord       out  1      address mux: 0=PC, 1=ALUOut
//  ir_we      out  1      IR load
//  pc_we      out  1      PC write
//  pc_src     out  2      0=ALU(PC+4) 1=ALUOut(branch tgt) 2=jump tgt 3=rs (jr)
//  reg_we     out  1      register file write
//  reg_dst    out  1      0=rt 1=rd
//  mem_to_reg out  1      0=ALUOut 1=MDR
//  alu_src_a  out  1      0=PC 1=rs
//  alu_src_b  out  2      0=rt 1=const 4 2=sext imm 3=sext imm<<2
//  alu_ctrl   out  4      ALU op code
//  retire     out  1      one-cycle pulse on last cycle of each instruction
//  instr_cnt  out  CNT_W  retired count, wraps to 0 after all-ones
//  trap       out  1      sticky: illegal op/funct (or timeout)
// BEHAVIOUR
//  - Reset (async, immediate): state=RST; all 1-bit outputs 0, pc_src=0, alu_src_b=0, alu_ctrl=ADD, instr_cnt=0.
//  - RST -> FETCH unconditionally (no memory request during/first cycle after reset).
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, ADD; hold until mem_ready; on ready edge: ir_we=1,
//    pc_we=1, pc_src=0, -> DECODE. ir_we/pc_we asserted only in the cycle mem_ready=1.
//  - DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target to ALUOut). Next by op:
//    R-type(00) legal funct -> EXEC; jr(funct 08) -> JUMP; addi 08/andi 0C/ori 0D/xori 0E/lui 0F/slti 0A -> EXEC;
//    lw 23/sw 2B -> ADDR; beq 04/bne 05 -> BRANCH; j 02 -> JUMP; anything else -> TRAP.
//  - EXEC: alu_src_a=1, alu_src_b = R ? 0 : 2, alu_ctrl from decoder -> ALUWB.
//  - ALUWB: reg_we=1, reg_dst = R-type, mem_to_reg=0, retire -> FETCH.
//  - ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEMRD (lw) / MEMWR (sw).
//  - MEMRD: mem_req=1, iord=1; wait mem_ready -> LDWB. MEMWR: same + mem_we=1; on ready retire -> FETCH.
//  - LDWB: reg_we=1, reg_dst=0, mem_to_reg=1, retire -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, SUB; pc_src=1; pc_we = beq ? zero : ~zero; retire -> FETCH.
//  - JUMP: pc_we=1, pc_src = (op==0) ? 3 : 2; retire -> FETCH.
//  - TRAP: all strobes 0, trap=1, no retire; remains until rst_n low.
//  - Latency (mem_ready always 1): R/I-ALU 4, lw 5, sw 4, branch/jump 3 cycles.
//  - Legal funct: 00 sll,02 srl,08 jr,20 add,22 sub,24 and,25 or,26 xor,27 nor,2A slt; others -> TRAP.
//  - ALU codes: AND 0000 OR 0001 ADD 0010 XOR 0011 SUB 0110 SLT 0111 SLL 1000 SRL 1001 LUI 1010 NOR 1100.
//  - instr_cnt increments by 1 on each retire; mem_ready outside a wait state is ignored.
// CONFIGURATION
//  MC_MEM_TIMEOUT_EN defined: 8-bit wait counter clears on entry to FETCH/MEMRD/MEMWR, counts each cycle
//    mem_ready=0; reaching TMO_CYC -> TRAP (trap=1, mem_req drops next cycle).
//  Undefined: no counter; memory waits are unbounded; TMO_CYC unused.
// STRUCTURE
//  mcpu_defs.vh (`include): opcode/funct constants, ALU codes, state encodings (4-bit, binary), pc_src/alu_src_b enums.
//  Sub-module mc_alu_dec: combinational op/funct -> alu_ctrl + legal flag; shared by EXEC and DECODE legality check.
//  FSM, output decode and instr_cnt/timeout counters in multicycle_ctrl.
// TESTING
//  1. rst_n=0 mid-MEMRD -> outputs to reset values same cycle; after release, RST then FETCH with mem_req=1.
//  2. op=00 funct=20, mem_ready=1 -> FETCH,DECODE,EXEC(alu_ctrl=0010),ALUWB(reg_we,reg_dst=1); instr_cnt 0->1.
//  3. op=23, mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, LDWB mem_to_reg=1, total 8 cycles.
//  4. op=04 zero=1 -> pc_we=1 pc_src=1; op=05 zero=1 -> pc_we=0; both retire in 3 cycles.
//  5. op=00 funct=08 -> JUMP pc_src=3; op=02 -> pc_src=2; op=3F -> TRAP, trap=1 sticky, no retire.
//  6. MC_MEM_TIMEOUT_EN, TMO_CYC=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles; undefined -> waits indefinitely.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared states, opcodes, ALU codes and control bundle for the multi-cycle sequencer
package multicycle_ctrl_pkg;

  // 4-bit binary state encoding
  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_ALUWB  = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEMRD  = 4'd6,
    ST_MEMWR  = 4'd7,
    ST_LDWB   = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_TRAP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RS     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Datapath controls that depend only on the state (registered as a bundle)
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    pc_src_e    pc_src;
    alu_src_b_e alu_src_b;
    logic [3:0] alu_ctrl;
    logic       trap;
  } ctrl_t;

  // Quiescent control word: everything off, ALU left on ADD
  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c.mem_req    = 1'b0;
    c.mem_we     = 1'b0;
    c.iord       = 1'b0;
    c.reg_we     = 1'b0;
    c.reg_dst    = 1'b0;
    c.mem_to_reg = 1'b0;
    c.alu_src_a  = 1'b0;
    c.pc_src     = PCSRC_ALU;
    c.alu_src_b  = SRCB_RT;
    c.alu_ctrl   = ALU_ADD;
    c.trap       = 1'b0;
    return c;
  endfunction

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// rtl/multicycle_ctrl_alu_dec.sv - combinational op/funct decoder giving ALU op code and instruction legality
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  // Map opcode (and funct for R-type) to ALU operation; unknown encodings are flagged illegal
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SLL:  alu_ctrl_o = ALU_SLL;
          FN_SRL:  alu_ctrl_o = ALU_SRL;
          FN_JR:   alu_ctrl_o = ALU_ADD;
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_ADDI:        alu_ctrl_o = ALU_ADD;
      OP_ANDI:        alu_ctrl_o = ALU_AND;
      OP_ORI:         alu_ctrl_o = ALU_OR;
      OP_XORI:        alu_ctrl_o = ALU_XOR;
      OP_LUI:         alu_ctrl_o = ALU_LUI;
      OP_SLTI:        alu_ctrl_o = ALU_SLT;
      OP_LW, OP_SW:   alu_ctrl_o = ALU_ADD;
      OP_BEQ, OP_BNE: alu_ctrl_o = ALU_SUB;
      OP_J:           alu_ctrl_o = ALU_ADD;
      default:        legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS sequencer FSM; optional memory-wait timeout under MC_MEM_TIMEOUT_EN
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             trap
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [3:0]       dec_alu_ctrl;
  logic             dec_legal;
  logic             is_rtype;
  logic             branch_take;
  logic             tmo_hit;

  multicycle_ctrl_alu_dec u_alu_dec (
    .op_i      (op),
    .funct_i   (funct),
    .alu_ctrl_o(dec_alu_ctrl),
    .legal_o   (dec_legal)
  );

  assign is_rtype    = (op == OP_RTYPE);
  assign branch_take = (op == OP_BEQ) ? zero : !zero;

`ifdef MC_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Fires on the last tolerated stall cycle so the next edge lands in TRAP
  assign tmo_hit = !mem_ready && (wait_cnt_q == 8'(TMO_CYC - 1));

  // Count stalled cycles in a memory wait; every state change restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if (is_wait_state(state_q) && !mem_ready) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TMO_CYC == 0);
`endif

  // Next-state selection from current state, memory handshake and decoded instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (tmo_hit) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          state_d = ST_TRAP;
        end else begin
          case (op)
            OP_RTYPE:       state_d = (funct == FN_JR) ? ST_JUMP : ST_EXEC;
            OP_LW, OP_SW:   state_d = ST_ADDR;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            OP_J:           state_d = ST_JUMP;
            default:        state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_ADDR:   state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready)    state_d = ST_LDWB;
        else if (tmo_hit) state_d = ST_TRAP;
      end
      ST_MEMWR: begin
        if (mem_ready)    state_d = ST_FETCH;
        else if (tmo_hit) state_d = ST_TRAP;
      end
      ST_LDWB:   state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_RST;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops
  always_comb begin
    ctrl_d = idle_ctrl();
    case (state_d)
      ST_FETCH: begin
        ctrl_d.mem_req   = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
      end
      ST_DECODE: ctrl_d.alu_src_b = SRCB_IMM_SH2;
      ST_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = is_rtype ? SRCB_RT : SRCB_IMM;
        ctrl_d.alu_ctrl  = dec_alu_ctrl;
      end
      ST_ALUWB: begin
        ctrl_d.reg_we  = 1'b1;
        ctrl_d.reg_dst = is_rtype;
      end
      ST_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.iord    = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.iord    = 1'b1;
        ctrl_d.mem_we  = 1'b1;
      end
      ST_LDWB: begin
        ctrl_d.reg_we     = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_ctrl  = ALU_SUB;
        ctrl_d.pc_src    = PCSRC_ALUOUT;
      end
      ST_JUMP:   ctrl_d.pc_src = is_rtype ? PCSRC_RS : PCSRC_JUMP;
      ST_TRAP:   ctrl_d.trap   = 1'b1;
      default:   ctrl_d = idle_ctrl();
    endcase
  end

  // State and registered control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      ctrl_q  <= idle_ctrl();
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
    end else if (retire) begin
      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  // Strobes qualified by same-cycle inputs (memory handshake, branch flag)
  assign ir_we  = (state_q == ST_FETCH) && mem_ready;
  assign pc_we  = ((state_q == ST_FETCH) && mem_ready) ||
                  ((state_q == ST_BRANCH) && branch_take) ||
                  (state_q == ST_JUMP);
  assign retire = (state_q == ST_ALUWB) || (state_q == ST_LDWB) ||
                  (state_q == ST_BRANCH) || (state_q == ST_JUMP) ||
                  ((state_q == ST_MEMWR) && mem_ready);

  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign iord       = ctrl_q.iord;
  assign pc_src     = ctrl_q.pc_src;
  assign reg_we     = ctrl_q.reg_we;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign trap       = ctrl_q.trap;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_ctrl;
  logic        retire, trap;
  logic [31:0] instr_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int cnt_model = 0;

  typedef struct {
    int         lat;
    logic [3:0] alu3;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       m2r;
    int         memcyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .TMO_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .retire(retire),
    .instr_cnt(instr_cnt), .trap(trap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected per-instruction behaviour from the instruction table
  function automatic exp_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int stall);
    exp_t e;
    e.lat = 4; e.alu3 = 4'b0010; e.pc_we = 1'b0; e.pc_src = 2'd0;
    e.reg_we = 1'b0; e.reg_dst = 1'b0; e.m2r = 1'b0; e.memcyc = 0;
    case (o)
      6'h00: begin
        if (f == 6'h08) begin
          e.lat = 3; e.pc_we = 1'b1; e.pc_src = 2'd3;
        end else begin
          e.reg_we = 1'b1; e.reg_dst = 1'b1;
          case (f)
            6'h00: e.alu3 = 4'b1000;
            6'h02: e.alu3 = 4'b1001;
            6'h22: e.alu3 = 4'b0110;
            6'h24: e.alu3 = 4'b0000;
            6'h25: e.alu3 = 4'b0001;
            6'h26: e.alu3 = 4'b0011;
            6'h27: e.alu3 = 4'b1100;
            6'h2A: e.alu3 = 4'b0111;
            default: e.alu3 = 4'b0010;
          endcase
        end
      end
      6'h08: e.reg_we = 1'b1;
      6'h0C: begin e.reg_we = 1'b1; e.alu3 = 4'b0000; end
      6'h0D: begin e.reg_we = 1'b1; e.alu3 = 4'b0001; end
      6'h0E: begin e.reg_we = 1'b1; e.alu3 = 4'b0011; end
      6'h0F: begin e.reg_we = 1'b1; e.alu3 = 4'b1010; end
      6'h0A: begin e.reg_we = 1'b1; e.alu3 = 4'b0111; end
      6'h23: begin e.lat = 5 + stall; e.reg_we = 1'b1; e.m2r = 1'b1; e.memcyc = 1 + stall; end
      6'h2B: begin e.lat = 4 + stall; e.memcyc = 1 + stall; end
      6'h04: begin e.lat = 3; e.alu3 = 4'b0110; e.pc_src = 2'd1; e.pc_we = z; end
      6'h05: begin e.lat = 3; e.alu3 = 4'b0110; e.pc_src = 2'd1; e.pc_we = !z; end
      6'h02: begin e.lat = 3; e.pc_we = 1'b1; e.pc_src = 2'd2; end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one instruction from FETCH; compare against the scoreboard when it retires
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int stall);
    int cyc = 0, left = stall, memcyc = 0, irwe = 0;
    logic [3:0] alu3 = 4'h0;
    bit done = 0;
    exp_t e;
    sb.push_back(model(o, f, z, stall));
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) begin op = o; funct = f; zero = z; end
      if (mem_req && iord && left > 0) begin mem_ready = 1'b0; left--; end
      else mem_ready = 1'b1;
      #1;
      cyc++;
      if (cyc == 1) chk({tag, "_fetch"}, {28'd0, mem_req, iord, alu_src_b}, {28'd0, 1'b1, 1'b0, 2'd1});
      if (cyc == 3) alu3 = alu_ctrl;
      if (mem_req && iord) memcyc++;
      if (ir_we) irwe++;
      if (retire) begin
        done = 1;
        e = sb.pop_front();
        chk({tag, "_lat"},    cyc,        e.lat);
        chk({tag, "_alu"},    alu3,       e.alu3);
        chk({tag, "_pcwe"},   pc_we,      e.pc_we);
        chk({tag, "_pcsrc"},  pc_src,     e.pc_src);
        chk({tag, "_regwe"},  reg_we,     e.reg_we);
        chk({tag, "_regdst"}, reg_dst,    e.reg_dst);
        chk({tag, "_m2r"},    mem_to_reg, e.m2r);
        chk({tag, "_memcyc"}, memcyc,     e.memcyc);
        chk({tag, "_irwe"},   irwe,       1);
        chk({tag, "_cnt"},    instr_cnt,  cnt_model);
        cnt_model++;
      end
    end
    if (!done) chk({tag, "_noretire"}, 0, 1);
  endtask

  // Illegal encoding: expect TRAP on cycle 3, sticky, never retiring
  task automatic run_trap(input string tag, input logic [5:0] o, input logic [5:0] f);
    int rets = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin op = o; funct = f; end
      mem_ready = 1'b1;
      #1;
      if (retire) rets++;
      if (c == 3) chk({tag, "_entry"}, trap, 1);
    end
    chk({tag, "_sticky"}, trap, 1);
    chk({tag, "_memreq"}, mem_req, 0);
    chk({tag, "_pcwe"}, pc_we, 0);
    chk({tag, "_rets"}, rets, 0);
    chk({tag, "_cnt"}, instr_cnt, cnt_model);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_model = 0;
    sb.delete();
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_memreq", mem_req, 0);
    chk("rst_alu", alu_ctrl, 4'b0010);
    chk("rst_srcb", alu_src_b, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_trap", trap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_first", mem_req, 0);

    run_instr("add",  6'h00, 6'h20, 1'b0, 0);
    run_instr("lw_st", 6'h23, 6'h00, 1'b0, 3);
    run_instr("sw",   6'h2B, 6'h00, 1'b0, 0);
    run_instr("beq1", 6'h04, 6'h00, 1'b1, 0);
    run_instr("bne1", 6'h05, 6'h00, 1'b1, 0);
    run_instr("jr",   6'h00, 6'h08, 1'b0, 0);
    run_instr("j",    6'h02, 6'h00, 1'b0, 0);
    run_instr("sub",  6'h00, 6'h22, 1'b0, 0);
    run_instr("and",  6'h00, 6'h24, 1'b0, 0);
    run_instr("or",   6'h00, 6'h25, 1'b0, 0);
    run_instr("xor",  6'h00, 6'h26, 1'b0, 0);
    run_instr("nor",  6'h00, 6'h27, 1'b0, 0);
    run_instr("slt",  6'h00, 6'h2A, 1'b0, 0);
    run_instr("sll",  6'h00, 6'h00, 1'b0, 0);
    run_instr("srl",  6'h00, 6'h02, 1'b0, 0);
    run_instr("addi", 6'h08, 6'h3F, 1'b0, 0);
    run_instr("andi", 6'h0C, 6'h00, 1'b0, 0);
    run_instr("ori",  6'h0D, 6'h00, 1'b0, 0);
    run_instr("xori", 6'h0E, 6'h00, 1'b0, 0);
    run_instr("lui",  6'h0F, 6'h00, 1'b0, 0);
    run_instr("slti", 6'h0A, 6'h00, 1'b0, 0);
    run_instr("beq0", 6'h04, 6'h00, 1'b0, 0);
    run_instr("bne0", 6'h05, 6'h00, 1'b0, 0);
    run_instr("lw",   6'h23, 6'h00, 1'b0, 0);
    run_instr("sw_st", 6'h2B, 6'h00, 1'b0, 2);
    @(negedge clk);
    #1;
    chk("cnt_total", instr_cnt, cnt_model);

    // Asynchronous reset while a load is waiting in MEMRD
    op = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_req && iord) begin found = 1; mem_ready = 1'b0; end
    end
    chk("memrd_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_memreq", mem_req, 0);
    chk("arst_iord", iord, 0);
    chk("arst_alu", alu_ctrl, 4'b0010);
    chk("arst_cnt", instr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    cnt_model = 0;
    sb.delete();
    #1;
    chk("arst_rst_state", mem_req, 0);
    @(negedge clk);
    #1;
    chk("arst_fetch", {30'd0, mem_req, iord}, {30'd0, 1'b1, 1'b0});
    run_instr("post_rst", 6'h00, 6'h20, 1'b0, 0);

    run_trap("trap_op", 6'h3F, 6'h00);
    do_reset();
    run_trap("trap_fn", 6'h00, 6'h01);
    do_reset();

    // Memory never answers in FETCH
`ifdef MC_MEM_TIMEOUT_EN
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (c == 4) chk("tmo_wait", {30'd0, mem_req, trap}, {30'd0, 1'b1, 1'b0});
      if (c == 5) chk("tmo_trap", {30'd0, mem_req, trap}, {30'd0, 1'b0, 1'b1});
    end
`else
    repeat (300) @(negedge clk);
    #1;
    chk("nowait_trap", {30'd0, mem_req, trap}, {30'd0, 1'b1, 1'b0});
    chk("nowait_cnt", instr_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
